// File: rtl/foc_loop_scheduler.sv
// Sequences one PI -> inverse-Park -> SVPWM -> ADC iteration per PWM period.
// It also measures iteration latency, flags overrun and timeout, and decimates completions into a speed-loop enable.
module foc_loop_scheduler #(
  parameter int unsigned PERIOD_CYCLES  = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 2000,
  parameter int unsigned SPEED_DIV      = 10
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iEnable,
  input  logic        iClear_fault,
  input  logic        iPI_done,
  input  logic        iIP_done,
  input  logic        iMod_done,
  input  logic        iADC_done,
  output logic        oCL_en,
  output logic        oSpeed_en,
  output logic        oBusy,
  output logic [2:0]  oStage,
  output logic        oOverrun,
  output logic        oTimeout,
  output logic [15:0] oLatency,
  output logic [15:0] oLoop_count
);
  localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SPEED_DIV + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_PI    = 3'd2,
    S_IP    = 3'd3,
    S_MOD   = 3'd4,
    S_ADC   = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] per_q, per_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [SW-1:0] spd_q, spd_d;
  logic [15:0]   lat_q, lat_d;
  logic [15:0]   lat_out_q, lat_out_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          cl_en_q, cl_en_d;
  logic          spd_en_q, spd_en_d;
  logic          ovr_q, ovr_d;
  logic          to_q, to_d;

  logic run, tick, busy, expired, complete;

  assign run      = iEnable && (state_q != S_FAULT);
  assign tick     = run && (per_q == PW'(PERIOD_CYCLES - 1));
  assign busy     = (state_q == S_PI) || (state_q == S_IP) || (state_q == S_MOD) || (state_q == S_ADC);
  assign expired  = busy && (tmr_q == TW'(TIMEOUT_CYCLES - 1));
  assign complete = iEnable && (state_q == S_ADC) && iADC_done;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iEnable) state_d = S_WAIT;
      S_WAIT:  if (tick) state_d = S_PI;
      // A done arriving on the expiry cycle still advances the stage.
      S_PI:    if (iPI_done) state_d = S_IP;   else if (expired) state_d = S_FAULT;
      S_IP:    if (iIP_done) state_d = S_MOD;  else if (expired) state_d = S_FAULT;
      S_MOD:   if (iMod_done) state_d = S_ADC; else if (expired) state_d = S_FAULT;
      S_ADC:   if (iADC_done) state_d = S_WAIT; else if (expired) state_d = S_FAULT;
      S_FAULT: if (iClear_fault) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!iEnable && (state_q != S_FAULT)) state_d = S_IDLE;
  end

  always_comb begin
    per_d = run ? (tick ? '0 : per_q + PW'(1)) : '0;

    if (state_d != state_q) tmr_d = '0;
    else if (busy)          tmr_d = tmr_q + TW'(1);
    else                    tmr_d = '0;

    cl_en_d = (state_q == S_WAIT) && (state_d == S_PI);

    // lat_q counts cycles of the iteration up to and including the current one.
    if (cl_en_d)                        lat_d = 16'd1;
    else if (busy && lat_q != 16'hFFFF) lat_d = lat_q + 16'd1;
    else                                lat_d = lat_q;

    lat_out_d = complete ? lat_q : lat_out_q;
    cnt_d     = complete ? cnt_q + 16'd1 : cnt_q;

    spd_d    = spd_q;
    spd_en_d = 1'b0;
    if (!iEnable) begin
      spd_d = '0;
    end else if (complete) begin
      if (spd_q + SW'(1) == SW'(SPEED_DIV)) begin
        spd_d    = '0;
        spd_en_d = 1'b1;
      end else begin
        spd_d = spd_q + SW'(1);
      end
    end

    if (tick && busy)     ovr_d = 1'b1;
    else if (iClear_fault) ovr_d = 1'b0;
    else                   ovr_d = ovr_q;

    if ((state_d == S_FAULT) && (state_q != S_FAULT)) to_d = 1'b1;
    else if (iClear_fault)                            to_d = 1'b0;
    else                                              to_d = to_q;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= S_IDLE;
      per_q     <= '0;
      tmr_q     <= '0;
      spd_q     <= '0;
      lat_q     <= '0;
      lat_out_q <= '0;
      cnt_q     <= '0;
      cl_en_q   <= 1'b0;
      spd_en_q  <= 1'b0;
      ovr_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_q     <= per_d;
      tmr_q     <= tmr_d;
      spd_q     <= spd_d;
      lat_q     <= lat_d;
      lat_out_q <= lat_out_d;
      cnt_q     <= cnt_d;
      cl_en_q   <= cl_en_d;
      spd_en_q  <= spd_en_d;
      ovr_q     <= ovr_d;
      to_q      <= to_d;
    end
  end

  assign oCL_en      = cl_en_q;
  assign oSpeed_en   = spd_en_q;
  assign oBusy       = busy;
  assign oStage      = state_q;
  assign oOverrun    = ovr_q;
  assign oTimeout    = to_q;
  assign oLatency    = lat_out_q;
  assign oLoop_count = cnt_q;
endmodule
